// File: rtl/ras_predictor.sv
// Return-address stack for the fetch front end. A speculative copy drives the
// jr $ra prediction, and a committed copy restores it on a mispredict flush.
module ras_predictor #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spec_push_i,
  input  logic [31:0]      spec_push_addr_i,
  input  logic             spec_pop_i,
  input  logic             cmt_push_i,
  input  logic [31:0]      cmt_push_addr_i,
  input  logic             cmt_pop_i,
  input  logic             flush_i,
  output logic [31:0]      ret_predict_addr_o,
  output logic             ret_predict_valid_o,
  output logic [PTR_W:0]   spec_count_o
);

  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = '0;
  localparam logic [PTR_W-1:0] SP_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] SP_ZERO   = '0;

  logic [31:0]      spec_entry_q [DEPTH];
  logic [31:0]      spec_entry_d [DEPTH];
  logic [PTR_W-1:0] spec_sp_q, spec_sp_d;
  logic [PTR_W:0]   spec_count_q, spec_count_d;

  logic [31:0]      cmt_entry_q [DEPTH];
  logic [31:0]      cmt_entry_d [DEPTH];
  logic [PTR_W-1:0] cmt_sp_q, cmt_sp_d;
  logic [PTR_W:0]   cmt_count_q, cmt_count_d;

  // Committed stack next state: follows resolved calls/returns every cycle.
  always_comb begin
    cmt_entry_d = cmt_entry_q;
    cmt_sp_d    = cmt_sp_q;
    cmt_count_d = cmt_count_q;
    if (cmt_push_i && cmt_pop_i) begin
      // Return-and-call replaces the top in place; an empty stack gains one entry.
      cmt_entry_d[cmt_sp_q] = cmt_push_addr_i;
      if (cmt_count_q == CNT_ZERO) begin
        cmt_count_d = CNT_ONE;
      end else begin
        cmt_count_d = cmt_count_q;
      end
    end else if (cmt_push_i) begin
      cmt_sp_d              = cmt_sp_q + SP_ONE;
      cmt_entry_d[cmt_sp_d] = cmt_push_addr_i;
      if (cmt_count_q == FULL_CNT) begin
        cmt_count_d = FULL_CNT;
      end else begin
        cmt_count_d = cmt_count_q + CNT_ONE;
      end
    end else if (cmt_pop_i) begin
      if (cmt_count_q != CNT_ZERO) begin
        cmt_sp_d    = cmt_sp_q - SP_ONE;
        cmt_count_d = cmt_count_q - CNT_ONE;
      end else begin
        cmt_sp_d    = cmt_sp_q;
        cmt_count_d = cmt_count_q;
      end
    end else begin
      cmt_sp_d    = cmt_sp_q;
      cmt_count_d = cmt_count_q;
    end
  end

  // Speculative stack next state: flush copies the committed next state wholesale.
  always_comb begin
    spec_entry_d = spec_entry_q;
    spec_sp_d    = spec_sp_q;
    spec_count_d = spec_count_q;
    if (flush_i) begin
      spec_entry_d = cmt_entry_d;
      spec_sp_d    = cmt_sp_d;
      spec_count_d = cmt_count_d;
    end else if (spec_push_i && spec_pop_i) begin
      spec_entry_d[spec_sp_q] = spec_push_addr_i;
      if (spec_count_q == CNT_ZERO) begin
        spec_count_d = CNT_ONE;
      end else begin
        spec_count_d = spec_count_q;
      end
    end else if (spec_push_i) begin
      spec_sp_d               = spec_sp_q + SP_ONE;
      spec_entry_d[spec_sp_d] = spec_push_addr_i;
      if (spec_count_q == FULL_CNT) begin
        spec_count_d = FULL_CNT;
      end else begin
        spec_count_d = spec_count_q + CNT_ONE;
      end
    end else if (spec_pop_i) begin
      if (spec_count_q != CNT_ZERO) begin
        spec_sp_d    = spec_sp_q - SP_ONE;
        spec_count_d = spec_count_q - CNT_ONE;
      end else begin
        spec_sp_d    = spec_sp_q;
        spec_count_d = spec_count_q;
      end
    end else begin
      spec_sp_d    = spec_sp_q;
      spec_count_d = spec_count_q;
    end
  end

  // Pointer and occupancy registers for both stacks.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_sp_q    <= SP_ZERO;
      spec_count_q <= CNT_ZERO;
      cmt_sp_q     <= SP_ZERO;
      cmt_count_q  <= CNT_ZERO;
    end else begin
      spec_sp_q    <= spec_sp_d;
      spec_count_q <= spec_count_d;
      cmt_sp_q     <= cmt_sp_d;
      cmt_count_q  <= cmt_count_d;
    end
  end

  // Entry storage carries no reset; it is simply held while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_entry_q <= spec_entry_q;
      cmt_entry_q  <= cmt_entry_q;
    end else begin
      spec_entry_q <= spec_entry_d;
      cmt_entry_q  <= cmt_entry_d;
    end
  end

  assign ret_predict_valid_o = (spec_count_q != CNT_ZERO);
  assign ret_predict_addr_o  = (spec_count_q != CNT_ZERO) ? spec_entry_q[spec_sp_q] : 32'h0000_0000;
  assign spec_count_o        = spec_count_q;

endmodule

// File: tb/tb_ras_predictor.sv
// Scoreboard bench for ras_predictor: the driver queues the expected post-edge
// outputs for every cycle it drives, and a monitor compares them after each edge.
module tb_ras_predictor;

  logic        clk;
  logic        rst;
  logic        spec_push_i;
  logic [31:0] spec_push_addr_i;
  logic        spec_pop_i;
  logic        cmt_push_i;
  logic [31:0] cmt_push_addr_i;
  logic        cmt_pop_i;
  logic        flush_i;
  logic [31:0] ret_predict_addr_o;
  logic        ret_predict_valid_o;
  logic [3:0]  spec_count_o;

  int checks;
  int failures;

  logic [31:0] exp_addr_q [$];
  logic [3:0]  exp_cnt_q  [$];
  string       exp_name_q [$];

  ras_predictor #(.DEPTH(8), .PTR_W(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .spec_push_i         (spec_push_i),
    .spec_push_addr_i    (spec_push_addr_i),
    .spec_pop_i          (spec_pop_i),
    .cmt_push_i          (cmt_push_i),
    .cmt_push_addr_i     (cmt_push_addr_i),
    .cmt_pop_i           (cmt_pop_i),
    .flush_i             (flush_i),
    .ret_predict_addr_o  (ret_predict_addr_o),
    .ret_predict_valid_o (ret_predict_valid_o),
    .spec_count_o        (spec_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after each rising edge, compare against the oldest queued expectation.
  initial begin
    logic [31:0] ea;
    logic [3:0]  ec;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        ec = exp_cnt_q.pop_front();
        nm = exp_name_q.pop_front();
        checks++;
        if (ret_predict_addr_o !== ea || spec_count_o !== ec ||
            ret_predict_valid_o !== (ec != 4'd0)) begin
          failures++;
          $display("FAIL %s: got addr=%h valid=%b count=%0d, expected addr=%h valid=%b count=%0d",
                   nm, ret_predict_addr_o, ret_predict_valid_o, spec_count_o,
                   ea, (ec != 4'd0), ec);
        end
      end
    end
  end

  task automatic step(input logic r, input logic sp, input logic [31:0] spa, input logic spp,
                      input logic cp, input logic [31:0] cpa, input logic cpp, input logic fl,
                      input logic [31:0] ea, input logic [3:0] ec, input string nm);
    @(negedge clk);
    rst              = r;
    spec_push_i      = sp;
    spec_push_addr_i = spa;
    spec_pop_i       = spp;
    cmt_push_i       = cp;
    cmt_push_addr_i  = cpa;
    cmt_pop_i        = cpp;
    flush_i          = fl;
    exp_addr_q.push_back(ea);
    exp_cnt_q.push_back(ec);
    exp_name_q.push_back(nm);
  endtask

  task automatic idle(input logic [31:0] ea, input logic [3:0] ec, input string nm);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ea, ec, nm);
  endtask

  task automatic spush(input logic [31:0] a, input logic [31:0] ea, input logic [3:0] ec, input string nm);
    step(1'b0, 1'b1, a, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ea, ec, nm);
  endtask

  task automatic spop(input logic [31:0] ea, input logic [3:0] ec, input string nm);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, ea, ec, nm);
  endtask

  initial begin
    int wait_cycles;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    spec_push_i = 1'b0; spec_push_addr_i = 32'h0; spec_pop_i = 1'b0;
    cmt_push_i = 1'b0; cmt_push_addr_i = 32'h0; cmt_pop_i = 1'b0; flush_i = 1'b0;

    // Reset and idle behaviour
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, "reset");
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, "reset_hold");
    idle(32'h0, 4'd0, "idle_after_reset");
    spop(32'h0, 4'd0, "pop_on_empty");

    // Basic push/pop
    spush(32'h8000_1008, 32'h8000_1008, 4'd1, "push1");
    spush(32'h8000_2010, 32'h8000_2010, 4'd2, "push2");
    spop(32'h8000_1008, 4'd1, "pop1");
    spop(32'h0, 4'd0, "pop2_empty");

    // Overflow: nine pushes into eight entries, then drain
    for (int i = 0; i < 9; i++) begin
      spush(32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), (i < 8) ? 4'(i + 1) : 4'd8, "ovf_push");
    end
    for (int k = 1; k <= 8; k++) begin
      spop((k < 8) ? 32'h120 - 32'(4 * k) : 32'h0, 4'(8 - k), "ovf_pop");
    end

    // Same-cycle push+pop
    spush(32'h1F0, 32'h1F0, 4'd1, "pp_setup1");
    spush(32'h200, 32'h200, 4'd2, "pp_setup2");
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 4'd2, "pushpop_top");
    spop(32'h1F0, 4'd1, "pp_pop_below");
    spop(32'h0, 4'd0, "pp_pop_empty");
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 4'd1, "pushpop_empty");
    spop(32'h0, 4'd0, "pp_drain");

    // Speculative divergence and flush restore
    step(1'b0, 1'b1, 32'hA00, 1'b0, 1'b1, 32'hA00, 1'b0, 1'b0, 32'hA00, 4'd1, "div_push_a");
    spush(32'hB00, 32'hB00, 4'd2, "div_push_b");
    spush(32'hC00, 32'hC00, 4'd3, "div_push_c");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA00, 4'd1, "flush_restore");
    spush(32'hB00, 32'hB00, 4'd2, "div2_push_b");
    spush(32'hC00, 32'hC00, 4'd3, "div2_push_c");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD00, 1'b0, 1'b1, 32'hD00, 4'd2, "flush_with_cmt_push");
    step(1'b0, 1'b1, 32'hEEE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD00, 4'd2, "flush_ignores_spec");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hD00, 4'd2, "cmt_pop_only");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA00, 4'd1, "flush_after_cmt_pop");

    // Reset mid-operation has priority over everything
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, "rst_clean");
    for (int i = 0; i < 5; i++) begin
      spush(32'h500 + 32'(4 * i), 32'h500 + 32'(4 * i), 4'(i + 1), "fill5");
    end
    step(1'b1, 1'b1, 32'h777, 1'b0, 1'b1, 32'h888, 1'b0, 1'b1, 32'h0, 4'd0, "rst_priority");
    spush(32'h400, 32'h400, 4'd1, "push_after_rst");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 4'd0, "flush_cmt_was_reset");

    idle(32'h0, 4'd0, "final_idle");

    wait_cycles = 0;
    while (exp_addr_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_addr_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_addr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_predictor.md
# ras_predictor

Return-address stack for the dual-issue fetch front end, next to the branch target buffer. It receives call/return notifications for the instruction pair in the second fetch stage and supplies the predicted target for `jr $ra` returns. The BTB keeps handling direct branches and `j`; this block covers returns, whose targets change with call context. It also keeps a committed copy, updated from execute-stage resolution, and rebuilds the speculative stack from it on a mispredict flush.

## Interface
- DEPTH, 8, number of stack entries (power of two, ≥2)
- PTR_W, log2(DEPTH), stack-pointer width
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- spec_push_i  input  1  second stage holds a call (`jal`/`jalr`/`bal`) this cycle
- spec_push_addr_i  input  32  return address of that call (call PC + 8, past the delay slot)
- spec_pop_i  input  1  second stage holds a return (type_ret) this cycle
- cmt_push_i  input  1  execute stage resolved a call
- cmt_push_addr_i  input  32  return address of the resolved call
- cmt_pop_i  input  1  execute stage resolved a return
- flush_i  input  1  execute-stage mispredict; restore the speculative stack
- ret_predict_addr_o  output  32  speculative top of stack; 0 when empty
- ret_predict_valid_o  output  1  speculative stack non-empty
- spec_count_o  output  PTR_W+1  speculative occupancy, 0..DEPTH

## Operation
- Two identical circular stacks (speculative, committed). Each has an entry array of DEPTH×32, a top pointer `sp` (PTR_W bits) and a count (PTR_W+1 bits).
- Push only: `sp <= sp+1` mod DEPTH, write `entry[sp+1]`, `count <= min(count+1, DEPTH)`.
  - When full, the oldest entry is overwritten silently and count stays DEPTH.
- Pop only:
  - If count>0: `sp <= sp-1` mod DEPTH, `count <= count-1`. Entry data is not cleared.
  - If count==0: no state change.
- Push and pop in the same cycle (`jalr` used as a return-and-call):
  - Overwrite `entry[sp]` with the push address; sp is unchanged.
  - If count==0, count becomes 1 and the write goes to `entry[sp]`.
- The committed stack follows the same rules with `cmt_*` inputs, every cycle, regardless of flush_i.
- flush_i=1:
  - The speculative entries, sp and count load the committed stack's next-state values, including any cmt op in the same cycle.
  - `spec_*` inputs in that cycle are ignored.
- The prediction output is combinational from the speculative state:
  - `ret_predict_addr_o = count>0 ? entry[sp] : 0`
  - `ret_predict_valid_o = count>0`
- A pop presented in cycle N does not see its own effect: cycle N's output is the address that return uses.
- rst=1: both stacks get sp=0 and count=0. Entry arrays are not reset.
  - Outputs during and after reset: addr 0, valid 0, spec_count_o 0.
  - Reset takes priority over flush and all push/pop inputs.

## Timing
- Prediction is zero-latency: valid in the same cycle as the second-stage lookup, and it feeds the `jr` target mux directly.
- Push/pop effects are visible on the outputs in the cycle after the inputs are sampled.
- Flush restore is visible in the cycle after flush_i. With a cmt op in the same cycle, that state already includes the op.
- No handshake: inputs are single-cycle pulses, one op per stack per cycle (both instructions of a pair cannot be calls/returns; the decoder guarantees this).
- Pointer arithmetic wraps modulo DEPTH. Count saturates at DEPTH and floors at 0.

## Test plan
- Reset then idle:
  - ret_predict_valid_o=0, ret_predict_addr_o=0, spec_count_o=0.
  - A pop on empty leaves all three unchanged.
- Push 0x80001008, then push 0x80002010, then pop, pop:
  - After the pushes, outputs show 0x80001008 then 0x80002010 with count 1 then 2.
  - After the first pop: 0x80001008, count 1.
  - After the second pop: valid 0, addr 0, count 0.
- Overflow with DEPTH=8: push 0x100,0x104,…,0x120 (9 pushes), then 8 pops.
  - Count holds at 8 and top=0x120.
  - The pops return 0x120 down to 0x104.
  - 0x100 is lost; count reaches 0.
- Same-cycle push+pop with top=0x200, push addr 0x300: top becomes 0x300, count unchanged.
  - On an empty stack: top 0x300, count 1.
- Speculative divergence:
  - cmt pushes 0xA00.
  - spec pushes 0xA00, then 0xB00, 0xC00 on a wrong path.
  - Assert flush_i: the next cycle shows top 0xA00, count 1.
  - Repeat with a same-cycle cmt push of 0xD00: the next cycle shows top 0xD00, count 2.
- Reset mid-operation:
  - Fill 5 entries, then assert rst together with spec_push_i and flush_i.
  - Next cycle: count 0, valid 0.
  - A following push of 0x400 gives top 0x400, count 1.
